// File: rtl/wei_buffer_writer.sv
// Weight buffer writer: scatters an x-major weight stream
// across N_BUF_X banks using the reader's address layout.
module wei_buffer_writer #(
  parameter int N_BUF_X    = 5,
  parameter int B_BUF_ADDR = 9,
  parameter int B_SHAPE    = 48,
  parameter int DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [B_SHAPE-1:0]            wei_shape,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_WIDTH-1:0]         s_data,
  output logic [N_BUF_X-1:0]            wren,
  output logic [B_BUF_ADDR*N_BUF_X-1:0] wraddr,
  output logic [DATA_WIDTH-1:0]         wrdata
);

  localparam int RXW = (N_BUF_X > 1) ? $clog2(N_BUF_X) : 1;
  localparam logic [RXW-1:0] RX_LAST = RXW'(N_BUF_X - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]            state;
  logic [7:0]            n_r;
  logic [15:0]           h_r;
  logic [15:0]           w_r;
  logic [7:0]            cc;
  logic [15:0]           y;
  logic [15:0]           x;
  logic [RXW-1:0]        rx;
  logic [B_BUF_ADDR:0]   addr_r;
  logic [B_BUF_ADDR:0]   base_r;

  logic [7:0]            n_in;
  logic [15:0]           h_in;
  logic [15:0]           w_in;
  logic                  shape_unused;
  logic                  empty;
  logic                  beat;
  logic                  last_cc;
  logic                  last_y;
  logic                  last_x;
  logic                  col_end;
  logic                  ovf;

  // Only c_wei>>6 matters; the channel remainder is dropped.
  assign n_in  = wei_shape[13:6];
  assign h_in  = wei_shape[31:16];
  assign w_in  = wei_shape[47:32];
  assign shape_unused = ^{wei_shape[15:14], wei_shape[5:0]};
  assign empty = (n_in == 8'd0) || (h_in == 16'd0) || (w_in == 16'd0);

  assign busy    = (state == S_WRITE);
  assign s_ready = busy;
  assign beat    = s_valid & s_ready;

  assign last_cc = (cc == n_r - 8'd1);
  assign last_y  = (y == h_r - 16'd1);
  assign last_x  = (x == w_r - 16'd1);
  assign col_end = last_cc & last_y;
  assign ovf     = addr_r[B_BUF_ADDR];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      n_r    <= '0;
      h_r    <= '0;
      w_r    <= '0;
      cc     <= '0;
      y      <= '0;
      x      <= '0;
      rx     <= '0;
      addr_r <= '0;
      base_r <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      wren   <= '0;
      wraddr <= '0;
      wrdata <= '0;
    end else begin
      wren   <= '0;
      wraddr <= '0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            err    <= 1'b0;
            n_r    <= n_in;
            h_r    <= h_in;
            w_r    <= w_in;
            cc     <= '0;
            y      <= '0;
            x      <= '0;
            rx     <= '0;
            addr_r <= '0;
            base_r <= '0;
            if (empty) done <= 1'b1;
            else       state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (beat) begin
            wrdata <= s_data;
            if (ovf) begin
              err <= 1'b1;
            end else begin
              wren[rx] <= 1'b1;
              wraddr[rx*B_BUF_ADDR +: B_BUF_ADDR] <=
                addr_r[B_BUF_ADDR-1:0];
            end
            if (last_cc) begin
              cc <= '0;
              if (last_y) y <= '0;
              else        y <= y + 16'd1;
            end else begin
              cc <= cc + 8'd1;
            end
            // Banks share a base until every bank got a column.
            if (col_end) begin
              x <= x + 16'd1;
              if (rx == RX_LAST) begin
                rx     <= '0;
                base_r <= addr_r + 1'b1;
                addr_r <= addr_r + 1'b1;
              end else begin
                rx     <= rx + 1'b1;
                addr_r <= base_r;
              end
            end else begin
              addr_r <= addr_r + 1'b1;
            end
            if (col_end && last_x) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wei_buffer_writer.sv
// Self-checking bench for wei_buffer_writer against an
// address-formula reference model.
module tb_wei_buffer_writer;

  localparam int NB = 5;
  localparam int BA = 9;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [47:0]     wei_shape = '0;
  logic            start = 1'b0;
  logic            busy;
  logic            done;
  logic            err;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [DW-1:0]   s_data = '0;
  logic [NB-1:0]   wren;
  logic [BA*NB-1:0] wraddr;
  logic [DW-1:0]   wrdata;

  int tests = 0;
  int fails = 0;
  int obs_bank[$];
  int obs_addr[$];

  wei_buffer_writer #(
    .N_BUF_X(NB), .B_BUF_ADDR(BA),
    .B_SHAPE(48), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .wei_shape(wei_shape),
    .start(start), .busy(busy), .done(done), .err(err),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .wren(wren), .wraddr(wraddr), .wrdata(wrdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_ready"}, 64'(s_ready), 64'd0);
    check({tag, "_wren"}, 64'(wren), 64'd0);
    check({tag, "_wraddr"}, 64'(wraddr), 64'd0);
    check({tag, "_wrdata"}, wrdata, 64'd0);
  endtask

  // gap: 0 = always valid, 1 = toggling, 2 = random
  task automatic run_tensor(input int c, input int h,
                            input int w, input int gap,
                            input int restart_at);
    int n, total, b, cyc;
    int bank_q[$];
    int addr_q[$];
    bit v, acc, busy_s, tog, any_ovf;
    logic [63:0] d;
    logic [NB-1:0] ew;
    logic [BA*NB-1:0] ea;
    n = (c >> 6) & 255;
    any_ovf = 0;
    for (int xi = 0; xi < w; xi++)
      for (int yi = 0; yi < h; yi++)
        for (int ci = 0; ci < n; ci++) begin
          bank_q.push_back(xi % NB);
          addr_q.push_back(n * (yi + h * (xi / NB)) + ci);
          if (n * (yi + h * (xi / NB)) + ci >= (1 << BA))
            any_ovf = 1;
        end
    total = bank_q.size();
    obs_bank.delete();
    obs_addr.delete();
    @(negedge clk);
    wei_shape = {16'(w), 16'(h), 16'(c)};
    start = 1'b1;
    @(posedge clk); #1;
    check("start_busy", 64'(busy), 64'd1);
    check("start_err_clr", 64'(err), 64'd0);
    @(negedge clk);
    start = 1'b0;
    b = 0;
    cyc = 0;
    tog = 1;
    while (b < total && cyc < 20000) begin
      v = (gap == 0) ? 1'b1 :
          (gap == 1) ? tog : 1'($urandom_range(0, 1));
      tog = !tog;
      d = {$urandom, $urandom};
      s_valid = v;
      s_data = d;
      start = (b == restart_at);
      busy_s = busy;
      @(posedge clk); #1;
      acc = v && busy_s;
      ew = '0;
      ea = '0;
      if (acc && addr_q[b] < (1 << BA)) begin
        ew[bank_q[b]] = 1'b1;
        ea = (BA*NB)'(addr_q[b]) << (BA * bank_q[b]);
      end
      check("wren", 64'(wren), 64'(ew));
      if (ew != 0) begin
        check("wraddr", 64'(wraddr), 64'(ea));
        check("wrdata", wrdata, d);
      end else if (!acc) begin
        check("wraddr_idle", 64'(wraddr), 64'd0);
      end
      for (int i = 0; i < NB; i++)
        if (wren[i]) begin
          obs_bank.push_back(i);
          obs_addr.push_back(int'((wraddr >> (BA * i)) & 'h1ff));
        end
      if (acc) b++;
      check("done", 64'(done), 64'(acc && b == total));
      cyc++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    start = 1'b0;
    check("beats_consumed", 64'(b), 64'(total));
    check("end_busy", 64'(busy), 64'd0);
    check("end_err", 64'(err), 64'(any_ovf));
    @(posedge clk); #1;
    check("post_done", 64'(done), 64'd0);
    check("post_wren", 64'(wren), 64'd0);
  endtask

  initial begin
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Constant valid, c=128 h=3 w=7
    run_tensor(128, 3, 7, 0, -1);
    check("t1_nwrites", 64'(obs_bank.size()), 64'd42);
    if (obs_bank.size() == 42) begin
      check("t1_b0_bank", 64'(obs_bank[0]), 64'd0);
      check("t1_b0_addr", 64'(obs_addr[0]), 64'd0);
      check("t1_b6_bank", 64'(obs_bank[6]), 64'd1);
      check("t1_b6_addr", 64'(obs_addr[6]), 64'd0);
      check("t1_b30_bank", 64'(obs_bank[30]), 64'd0);
      check("t1_b30_addr", 64'(obs_addr[30]), 64'd6);
      check("t1_b41_bank", 64'(obs_bank[41]), 64'd1);
      check("t1_b41_addr", 64'(obs_addr[41]), 64'd11);
    end

    // Toggling valid
    run_tensor(128, 3, 7, 1, -1);
    check("t2_nwrites", 64'(obs_bank.size()), 64'd42);

    // Empty tensor: n_wrap_c = 0
    @(negedge clk);
    wei_shape = {16'd3, 16'd3, 16'd32};
    start = 1'b1;
    @(posedge clk); #1;
    check("empty_done", 64'(done), 64'd1);
    check("empty_busy", 64'(busy), 64'd0);
    check("empty_wren", 64'(wren), 64'd0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("empty_done_end", 64'(done), 64'd0);
    check("empty_busy2", 64'(busy), 64'd0);

    // Fill to the last bank address, then overflow
    run_tensor(1024, 8, 20, 0, -1);
    check("t4_nwrites", 64'(obs_bank.size()), 64'd2560);
    for (int i = obs_bank.size() - 1; i >= 0; i--)
      if (obs_bank[i] == 0) begin
        check("t4_bank0_last", 64'(obs_addr[i]), 64'd511);
        break;
      end
    run_tensor(1024, 8, 21, 0, -1);
    check("t4_ovf_nwrites", 64'(obs_bank.size()), 64'd2560);

    // Start pulsed mid-WRITE is ignored
    run_tensor(128, 3, 7, 1, 10);

    // Asynchronous reset mid-WRITE
    @(negedge clk);
    wei_shape = {16'd4, 16'd4, 16'd256};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s_valid = 1'b1;
    repeat (7) begin
      s_data = {$urandom, $urandom};
      @(negedge clk);
    end
    check("pre_abort_busy", 64'(busy), 64'd1);
    check("pre_abort_wren", 64'(wren), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("abort");
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_tensor(128, 3, 7, 0, -1);
    check("restart_bank", 64'(obs_bank[0]), 64'd0);
    check("restart_addr", 64'(obs_addr[0]), 64'd0);

    // Random shapes with random gaps
    for (int k = 0; k < 8; k++)
      run_tensor($urandom_range(64, 512),
                 $urandom_range(1, 10),
                 $urandom_range(1, 10), 2, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
